// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the uart_rx byte receiver: byte handshake plus error flags.
// PARITY_ERR exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
    logic [7:0] DATA;
    logic       VALID;
    logic       READY;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       ERR_CLR;
`ifdef UART_RX_PARITY_EN
    logic       PARITY_ERR;
`endif

    modport master (
        output DATA, VALID, FRAME_ERR, OVERRUN,
`ifdef UART_RX_PARITY_EN
        output PARITY_ERR,
`endif
        input  READY, ERR_CLR
    );

    modport slave (
        input  DATA, VALID, FRAME_ERR, OVERRUN,
`ifdef UART_RX_PARITY_EN
        input  PARITY_ERR,
`endif
        output READY, ERR_CLR
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, one-byte holding register and error flags.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop (PARITY_ODD selects odd).
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned CNT_W        = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD   = 1'b0
`endif
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      RXD,
    uart_rx_if.master rx_bus
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             sync1_q, sync2_q;
    logic             rx_s;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             deliver;
    logic             bit_end;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             parity_err_q, parity_err_d;
`endif

    assign rx_s    = sync2_q;
    assign bit_end = (cnt_q == BIT_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            sync1_q      <= RXD;
            sync2_q      <= sync1_q;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Half-bit check filters glitches and aligns later samples to mid-bit.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    par_bad_d = ((^{shift_q, rx_s}) != PARITY_ODD);
                    cnt_d     = '0;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        deliver      = !par_bad_q;
                        parity_err_d = par_bad_q;
`else
                        deliver      = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A pop and a push in the same cycle keep VALID high; ERR_CLR loses to a new overrun.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q & ~rx_bus.ERR_CLR;
        if (valid_q && rx_bus.READY) begin
            valid_d = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || rx_bus.READY) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rx_bus.DATA      = data_q;
    assign rx_bus.VALID     = valid_q;
    assign rx_bus.FRAME_ERR = frame_err_q;
    assign rx_bus.OVERRUN   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign rx_bus.PARITY_ERR = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (8N1 build): directed scenarios plus random frames
// checked against a transaction-level model of the holding register and error flags.
module tb_uart_rx;

    localparam int unsigned CPB = 8;

    logic clk;
    logic rst;
    logic rxd;

    uart_rx_if bus ();

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (16)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .RXD   (rxd),
        .rx_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [7:0] exp_q[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ovr   = 1'b0;
    int         fe_exp  = 0;

    // Monitor state
    int fe_seen  = 0;
    int valid_hi = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.FRAME_ERR) fe_seen++;
            if (bus.VALID) valid_hi++;
            if (bus.VALID && bus.READY) begin
                if (exp_q.size() == 0)
                    check_eq("pop_unexpected", exp_q.size(), 1);
                else
                    check_eq("pop_data", bus.DATA, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input int tail);
        rxd = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            step(CPB);
        end
        rxd = stop;
        step(CPB);
        if (tail > 0) step(tail);
        rxd = 1'b1;
        step(2 * CPB);
    endtask

    task automatic set_ready(input bit r);
        bus.READY = r;
        if (r && m_valid) begin
            exp_q.push_back(m_data);
            m_valid = 1'b0;
        end
    endtask

    task automatic clear_err();
        bus.ERR_CLR = 1'b1;
        step(1);
        bus.ERR_CLR = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic check_state();
        check_eq("valid", bus.VALID, m_valid);
        check_eq("overrun", bus.OVERRUN, m_ovr);
        if (m_valid) check_eq("data", bus.DATA, m_data);
        check_eq("frame_err_count", fe_seen, fe_exp);
    endtask

    task automatic frame(input logic [7:0] b, input bit stop, input int tail);
        if (!stop) fe_exp++;
        else if (m_valid && !bus.READY) m_ovr = 1'b1;
        else if (bus.READY) exp_q.push_back(b);
        else begin
            m_valid = 1'b1;
            m_data  = b;
        end
        send_frame(b, stop, tail);
        check_state();
    endtask

    initial begin
        int vc0;
        rst = 1'b1;
        rxd = 1'b1;
        bus.READY   = 1'b0;
        bus.ERR_CLR = 1'b0;
        step(3);
        check_eq("rst_valid", bus.VALID, 0);
        check_eq("rst_data", bus.DATA, 0);
        check_eq("rst_frame_err", bus.FRAME_ERR, 0);
        check_eq("rst_overrun", bus.OVERRUN, 0);
        rst = 1'b0;
        step(5);

        // Single good byte with READY high
        set_ready(1'b1);
        vc0 = valid_hi;
        frame(8'hA5, 1'b1, 0);
        check_eq("a5_valid_cycles", valid_hi - vc0, 1);

        // Short low glitch on idle line
        rxd = 1'b0;
        step(3);
        rxd = 1'b1;
        step(4 * CPB);
        check_state();

        // Framing error followed by a break, then a clean frame
        frame(8'h3C, 1'b0, 40);
        frame(8'h81, 1'b1, 0);

        // Overrun with consumer stalled
        set_ready(1'b0);
        frame(8'h11, 1'b1, 0);
        frame(8'h22, 1'b1, 0);
        set_ready(1'b1);
        step(2);
        check_state();
        clear_err();
        check_state();

        // READY in exactly the cycle the next byte is delivered
        set_ready(1'b0);
        frame(8'h44, 1'b1, 0);
        exp_q.push_back(8'h44);
        m_valid = 1'b1;
        m_data  = 8'h22;
        fork
            send_frame(8'h22, 1'b1, 0);
            begin
                step(9 * CPB + CPB / 2 + 2);
                bus.READY = 1'b1;
                step(1);
                bus.READY = 1'b0;
            end
        join
        check_state();
        check_eq("simul_popped", exp_q.size(), 0);

        // Overrun, then reset during data bit 4 of 0xFF
        frame(8'h33, 1'b1, 0);
        rxd = 1'b0;
        step(CPB);
        rxd = 1'b1;
        step(4 * CPB + CPB / 2);
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", bus.VALID, 0);
        check_eq("midrst_data", bus.DATA, 0);
        check_eq("midrst_frame_err", bus.FRAME_ERR, 0);
        check_eq("midrst_overrun", bus.OVERRUN, 0);
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ovr   = 1'b0;
        step(3);
        rst = 1'b0;
        step(2 * CPB);
        set_ready(1'b1);
        frame(8'h5A, 1'b1, 0);

        // Random frames, READY levels and error clears
        for (int k = 0; k < 30; k++) begin
            logic [7:0] b;
            bit         stop;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            set_ready($urandom_range(0, 2) != 0);
            step(2);
            if ($urandom_range(0, 3) == 0) clear_err();
            frame(b, stop, stop ? 0 : int'($urandom_range(0, 30)));
        end

        set_ready(1'b1);
        step(4);
        check_eq("final_valid", bus.VALID, 0);
        check_eq("final_pending", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver placed directly upstream of the blinky top-level logic.
- Deserialises the 8N1 stream on the board RXD pin into bytes and hands them to the consumer over a VALID/READY handshake.
- Holds one byte; reports framing and overrun errors.
- Sample point is fixed at mid-bit, counted from the detected start edge.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); legal range 4..65535.
- CNT_W, 16, width of the baud counter; must hold CLKS_PER_BIT-1.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- RXD  input  1  raw serial line, idle high, asynchronous to CLK.
- DATA  output  8  received byte, valid while VALID=1.
- VALID  output  1  holding register full.
- READY  input  1  consumer accepts DATA when VALID&&READY at a rising edge.
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled 0.
- OVERRUN  output  1  sticky: a good byte was dropped because the holding register was full.
- ERR_CLR  input  1  synchronous clear of OVERRUN.

Behaviour:
- Reset (async, RST=1): state IDLE, counter 0, bit index 0, both sync flops 1, DATA=8'h00, VALID=0, FRAME_ERR=0, OVERRUN=0.
- Synchroniser: RXD passes two flops to form rx_s (2-cycle delay). The FSM sees only rx_s.
- IDLE: if rx_s==0, go to START with cnt=0.
- START: cnt increments each cycle. At cnt==CLKS_PER_BIT/2-1 (integer divide):
  - rx_s==0: go to DATA, cnt=0, idx=0.
  - rx_s==1: glitch; return to IDLE with no outputs.
- DATA: at cnt==CLKS_PER_BIT-1:
  - shift rx_s into the shift register LSB-first; cnt=0; idx++.
  - after idx 7 is sampled, go to STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
  - 1: deliver the byte (see holding register); go to IDLE.
  - 0: FRAME_ERR=1 for exactly one cycle; byte discarded; go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break condition from re-triggering reception.
- Holding register, on a deliver event:
  - VALID=0, or VALID&&READY in the same cycle: DATA<=byte, VALID<=1 (a simultaneous pop and push keeps VALID high).
  - VALID=1 and READY=0: byte dropped, OVERRUN<=1, DATA unchanged.
- Handshake:
  - VALID&&READY with no deliver event: VALID<=0 next cycle.
  - DATA is stable while VALID=1 and READY=0.
  - READY has no effect while VALID=0.
- Latency: VALID rises on the edge after the mid-stop sample, so DATA is presented before the nominal line end of frame.
- OVERRUN: ERR_CLR=1 clears it. If ERR_CLR and a new overrun coincide, set wins.
- Reset mid-frame: immediate return to IDLE, partial byte lost, VALID=0.
- FRAME_ERR and OVERRUN never assert in the same cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
  - Defined: a PARITY state sits between DATA and STOP and samples one bit at the full-bit point.
    - New parameter PARITY_ODD, default 0 (0 = even parity).
    - New output PARITY_ERR, one-cycle pulse when the sampled parity mismatches; asserts in the cycle after the stop sample.
    - A byte with a parity error is dropped.
    - The stop bit is still checked; on a stop bit of 0 only FRAME_ERR pulses.
  - Undefined: frame is 8N1 and the PARITY_ERR port does not exist.

Test Plan:
- CLKS_PER_BIT=8, READY=1, send 8'hA5 as 8N1 -> VALID high one cycle, DATA=8'hA5, FRAME_ERR=0, OVERRUN=0.
- RXD low pulse of 3 cycles on an idle line -> START aborts to IDLE; VALID, FRAME_ERR, OVERRUN stay 0.
- Send 8'h3C with stop bit 0, then hold RXD low 40 cycles, then high -> FRAME_ERR pulses once, no VALID; next frame 8'h81 received correctly.
- READY=0, send 8'h11 then 8'h22 -> VALID=1, DATA=8'h11, OVERRUN=1. Assert READY -> VALID falls. Pulse ERR_CLR -> OVERRUN=0.
- READY asserted in exactly the cycle the second byte 8'h22 is delivered -> DATA=8'h22, VALID stays 1, OVERRUN=0.
- Assert RST during DATA bit 4 of 8'hFF, release, then send 8'h5A -> only 8'h5A delivered; outputs at reset values during RST.
